// File: rtl/branch_compare_unit_pkg.sv
// Shared definitions for branch_compare_unit: RV32I branch funct3 codes,
// FSM state encoding and the taken/illegal decode helpers.
package branch_compare_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = lt;
      F3_BGE:  t = !lt;
      F3_BLTU: t = ltu;
      F3_BGEU: t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic funct3_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/branch_compare_unit_chunk_compare.sv
// Combinational CHUNK-wide compare: inequality via xor-reduce plus a
// magnitude compare that is signed or unsigned depending on signed_mode.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_mode,
  output logic             neq,
  output logic             lt
);

  assign neq = |(a ^ b);

  always_comb begin
    lt = 1'b0;
    if (signed_mode) lt = $signed(a) < $signed(b);
    else             lt = a < b;
  end

endmodule

// File: rtl/branch_compare_unit.sv
// Multi-cycle branch comparator scanning operands MSB-first, CHUNK bits per cycle.
// Define BRANCH_CMP_EARLY_EXIT_EN to leave SCAN on the first differing chunk.
module branch_compare_unit
  import branch_compare_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq,
  output logic             lt,
  output logic             ltu,
  output logic             illegal,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_r, b_r;
  logic [2:0]        f3_r;
  logic [IDXW-1:0]   idx;
  logic              decided, eq_r, lt_r, ltu_r;

  logic [CHUNK-1:0]  a_ch [NCHUNK];
  logic [CHUNK-1:0]  b_ch [NCHUNK];
  logic [CHUNK-1:0]  cur_a, cur_b;
  logic              top_chunk, c_neq, c_lt, c_ltu;
  logic              accept, exit_scan;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
    assign a_ch[gi] = a_r[gi*CHUNK +: CHUNK];
    assign b_ch[gi] = b_r[gi*CHUNK +: CHUNK];
  end

  assign cur_a     = a_ch[idx];
  assign cur_b     = b_ch[idx];
  assign top_chunk = (idx == IDXW'(NCHUNK - 1));

  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a           (cur_a),
    .b           (cur_b),
    .signed_mode (top_chunk),
    .neq         (c_neq),
    .lt          (c_lt)
  );

  // When the top chunk's sign bits differ, the unsigned order is the inverse of the signed one.
  assign c_ltu = c_lt ^ (top_chunk & (cur_a[CHUNK-1] ^ cur_b[CHUNK-1]));

  assign accept    = (state == IDLE) && in_valid && !flush;
  assign exit_scan = (idx == '0) || (EARLY_EXIT && c_neq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SCAN;
      SCAN: begin
        if (flush)          state_next = IDLE;
        else if (exit_scan) state_next = DONE;
      end
      DONE: begin
        if (flush)          state_next = IDLE;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      f3_r    <= '0;
      idx     <= '0;
      decided <= 1'b0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      ltu_r   <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      f3_r    <= funct3;
      idx     <= IDXW'(NCHUNK - 1);
      decided <= 1'b0;
      eq_r    <= 1'b1;
      lt_r    <= 1'b0;
      ltu_r   <= 1'b0;
    end else if (state == SCAN && !flush) begin
      // Only the first differing chunk (MSB-first) sets the ordering flags.
      if (c_neq && !decided) begin
        decided <= 1'b1;
        eq_r    <= 1'b0;
        lt_r    <= c_lt;
        ltu_r   <= c_ltu;
      end
      if (!exit_scan) idx <= idx - 1'b1;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    eq        = out_valid & eq_r;
    lt        = out_valid & lt_r;
    ltu       = out_valid & ltu_r;
    taken     = out_valid & branch_taken(f3_r, eq_r, lt_r, ltu_r);
    illegal   = out_valid & funct3_illegal(f3_r);
  end

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed self-checking bench for branch_compare_unit (WIDTH=32, CHUNK=8).
module tb_branch_compare_unit;

`ifdef BRANCH_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 0, rst = 1;
  logic        in_valid = 0, flush = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic [2:0]  funct3 = 0;
  logic        in_ready, out_valid, taken, eq, lt, ltu, illegal, busy;

  int checks = 0, errors = 0;

  branch_compare_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .funct3(funct3), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .eq(eq), .lt(lt), .ltu(ltu), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] f3);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_before_accept", in_ready, 1);
    a = av; b = bv; funct3 = f3; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] f3, input logic [4:0] exp_tel, input int exp_lat);
    int lat;
    start_op(av, bv, f3);
    wait_out(lat);
    check({tag, "_latency"}, lat, exp_lat);
    // exp_tel = {taken, eq, lt, ltu, illegal}
    check({tag, "_flags"}, {taken, eq, lt, ltu, illegal}, {27'd0, exp_tel});
    @(posedge clk); #1;
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int lat, seen;
    logic [4:0] held;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1 check("post_rst_in_ready", in_ready, 1);

    run_op("beq_equal",  32'h12345678, 32'h12345678, 3'b000, 5'b11000, 4);
    run_op("blt_sign",   32'h80000000, 32'h00000001, 3'b100, 5'b10100, EE ? 1 : 4);
    run_op("bltu_sign",  32'h80000000, 32'h00000001, 3'b110, 5'b00100, EE ? 1 : 4);
    run_op("bltu_mid",   32'h000000FF, 32'h00000100, 3'b110, 5'b10110, EE ? 3 : 4);
    run_op("bgeu_mid",   32'h000000FF, 32'h00000100, 3'b111, 5'b00110, EE ? 3 : 4);
    run_op("illegal011", 32'h00000000, 32'h00000000, 3'b011, 5'b01001, 4);

    // Backpressure in DONE
    out_ready = 0;
    start_op(32'h80000000, 32'h00000001, 3'b100);
    wait_out(lat);
    held = {taken, eq, lt, ltu, illegal};
    check("bp_flags", held, 5'b10100);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || {taken, eq, lt, ltu, illegal} != held) seen++;
    end
    check("bp_stable_cycles_bad", seen, 0);
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_release_busy", busy, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Flush in the second SCAN cycle
    start_op(32'h00000011, 32'h00000011, 3'b000);
    @(posedge clk); #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush_busy", busy, 0);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("flush_no_out_valid", seen, 0);
    run_op("bge_after_flush", 32'd5, 32'd7, 3'b101, 5'b00110, 4);

    // Flush in IDLE blocks acceptance
    a = 1; b = 2; funct3 = 3'b000; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    check("idle_flush_blocks", busy, 0);

    // Async reset mid-SCAN
    start_op(32'hCAFEBABE, 32'hCAFEBABE, 3'b000);
    @(posedge clk); #1;
    check("scan_busy", busy, 1);
    #2 rst = 1;
    #1;
    check("arst_scan_busy", busy, 0);
    check("arst_scan_in_ready", in_ready, 0);
    @(negedge clk) rst = 0;
    #1 check("arst_release_in_ready", in_ready, 1);

    // Async reset mid-DONE
    out_ready = 0;
    start_op(32'h1, 32'h1, 3'b000);
    wait_out(lat);
    #2 rst = 1;
    #1 check("arst_done_out_valid", out_valid, 0);
    @(negedge clk) rst = 0;
    out_ready = 1;
    @(posedge clk); #1;
    check("arst_done_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_compare_unit.md
Name: branch_compare_unit

Overview:
- Parametrised multi-cycle branch comparator for the pipeline's branch-resolution path; successor to the fixed 32-bit single-cycle equality compare.
- Scans operands CHUNK bits per cycle from MSB to LSB and produces eq, signed-lt and unsigned-lt flags plus a taken decision for all six RV32I branch funct3 codes.
- Uses a valid/ready handshake on both sides, with flush support for pipeline squash.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK, with NCHUNK >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand/funct3 valid
- in_ready  output  1  unit can accept; high only in IDLE, and low while rst is high
- a  input  WIDTH  operand rs1
- b  input  WIDTH  operand rs2
- funct3  input  3  branch condition
- flush  input  1  synchronous squash of any in-flight op
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- taken  output  1  branch condition true
- eq  output  1  a == b
- lt  output  1  a < b, signed
- ltu  output  1  a < b, unsigned
- illegal  output  1  funct3 is 010 or 011
- busy  output  1  state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, chunk index=0, decided=0; all outputs 0, including in_ready while rst is asserted.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, funct3; idx=NCHUNK-1; decided=0, eq_r=1, lt_r=0, ltu_r=0; go to SCAN.
- SCAN, each cycle, compares chunk idx of the latched operands:
  - If chunks differ and decided=0: set decided=1, eq_r=0, ltu_r = unsigned chunk compare.
  - lt_r = signed chunk compare when idx==NCHUNK-1, else the unsigned chunk compare.
  - After a chunk is processed:
    - If idx==0, go to DONE.
    - If it differed and early exit is enabled, go to DONE.
    - Otherwise idx decrements.
  - Once decided=1, later chunks never alter the flags.
- DONE:
  - out_valid=1; eq, lt, ltu, taken and illegal are driven from registers and held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE. No accept occurs in the same cycle; in_ready rises the next cycle.
- taken by funct3:
  - 000: eq
  - 001: !eq
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
  - 010/011: taken=0, illegal=1
- Latency is counted in cycles from the accept edge to out_valid high.
  - With early exit: (number of chunks scanned up to and including the first differing chunk), range 1..NCHUNK; NCHUNK when equal.
  - Without early exit: always NCHUNK.
- flush:
  - In SCAN or DONE, forces IDLE on the next edge and drops out_valid. It has priority over the out handshake in the same cycle.
  - In IDLE, flush blocks acceptance that cycle.
- Async reset mid-SCAN or mid-DONE: out_valid drops immediately and the op is lost.
- NCHUNK==1: single SCAN cycle; the signed compare applies to the whole word.

Optional Feature:
- Macro BRANCH_CMP_EARLY_EXIT_EN.
- Defined: SCAN exits to DONE on the first differing chunk, giving variable latency.
- Undefined: SCAN always visits all NCHUNK chunks, giving fixed deterministic latency NCHUNK; results are identical.

Decomposition:
- Shared package:
  - funct3 constants: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - FSM state encoding: IDLE=0, SCAN=1, DONE=2.
- Sub-module chunk_compare: combinational, CHUNK-wide, with a signed_mode input.
  - Outputs: neq, lt.
  - Internally an xor-reduce for neq plus a magnitude compare.
  - Instantiated once in branch_compare_unit, fed by a chunk mux on idx.

Test Plan (WIDTH=32, CHUNK=8, out_ready=1 unless stated):
- a=0x12345678, b=0x12345678, funct3=000 -> taken=1, eq=1, lt=0, ltu=0; out_valid exactly 4 cycles after accept (both macro settings).
- a=0x80000000, b=0x00000001, funct3=100 -> taken=1, lt=1, ltu=0; latency 1 with early exit, 4 without. Repeat with funct3=110 -> taken=0.
- a=0x000000FF, b=0x00000100, funct3=110 -> ltu=1, lt=1, taken=1; latency 3 with early exit, 4 without. funct3=111 -> taken=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and flags stable, in_ready=0. Raise out_ready -> busy=0 and in_ready=1 on the next cycle.
- flush asserted in the second SCAN cycle -> no out_valid ever for that op. A following op a=5, b=7, funct3=101 -> taken=0.
- funct3=011 -> illegal=1, taken=0. Separately, assert rst mid-SCAN -> out_valid=0 and busy=0 asynchronously, and in_ready=1 after rst deasserts.
